// File: rtl/disp_fetch_ctrl.sv
// AXI4 read master fetching one display frame from VRAM per AXISTART edge.
// Optional RRESP error flag enabled by defining DISP_FETCH_RRESP_CHECK_EN.
`timescale 1ns/1ps

module disp_fetch_ctrl #(
    parameter int         H_PIXELS    = 1024,
    parameter int         V_LINES     = 768,
    parameter int         BYTES_PP    = 2,
    parameter int         BUS_BYTES   = 8,
    parameter int         BURST_BYTES = 64,
    parameter logic [3:0] ADDR_HI     = 4'h1
) (
    input  logic        ACLK,
    input  logic        ARST,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic        RVALID,
    input  logic        RLAST,
    output logic        RREADY,
`ifdef DISP_FETCH_RRESP_CHECK_EN
    input  logic [1:0]  RRESP,
    output logic        RDERR,
`endif
    input  logic        AXISTART,
    input  logic        DISPON,
    input  logic [27:0] DISPADDR,
    input  logic [15:0] DISPSTRIDE,
    input  logic        FIFOREADY,
    output logic        BUSY,
    output logic        FRAMEDONE
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_ADDR = 2'd1;
    localparam logic [1:0]  S_DATA = 2'd2;
    localparam logic [1:0]  S_WAIT = 2'd3;

    localparam logic [27:0] LINE_BYTES = 28'(H_PIXELS * BYTES_PP);
    localparam logic [27:0] BURST_STEP = 28'(BURST_BYTES);
    localparam logic [15:0] LAST_LINE  = 16'(V_LINES - 1);

    logic [1:0]  state_r, state_nxt_s;
    logic [27:0] line_base_r, line_base_nxt_s;
    logic [27:0] col_off_r, col_off_nxt_s;
    logic [15:0] stride_r, stride_nxt_s;
    logic [15:0] line_cnt_r, line_cnt_nxt_s;
    logic [31:0] araddr_r;
    logic        arvalid_r, rready_r, busy_r, framedone_r, done_nxt_s;
    logic        sync1_r, sync2_r, sync3_r;
    logic        start_s, burst_end_s;
    logic [27:0] col_next_s;

    assign ARLEN     = 8'(BURST_BYTES / BUS_BYTES - 1);
    assign ARSIZE    = 3'($clog2(BUS_BYTES));
    assign ARBURST   = 2'b01;
    assign ARADDR    = araddr_r;
    assign ARVALID   = arvalid_r;
    assign RREADY    = rready_r;
    assign BUSY      = busy_r;
    assign FRAMEDONE = framedone_r;

    assign start_s     = sync2_r & ~sync3_r & DISPON & (state_r == S_IDLE);
    assign burst_end_s = RVALID & RLAST & rready_r;
    assign col_next_s  = col_off_r + BURST_STEP;

    // AXISTART synchroniser and edge-detect stage
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= AXISTART;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Next-state and fetch-pointer computation
    always_comb begin
        state_nxt_s     = state_r;
        line_base_nxt_s = line_base_r;
        col_off_nxt_s   = col_off_r;
        stride_nxt_s    = stride_r;
        line_cnt_nxt_s  = line_cnt_r;
        done_nxt_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    line_base_nxt_s = DISPADDR;
                    stride_nxt_s    = DISPSTRIDE;
                    col_off_nxt_s   = 28'd0;
                    line_cnt_nxt_s  = 16'd0;
                    state_nxt_s     = S_ADDR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (ARREADY) begin
                    state_nxt_s = S_DATA;
                end else begin
                    state_nxt_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (burst_end_s) begin
                    if (col_next_s == LINE_BYTES) begin
                        col_off_nxt_s   = 28'd0;
                        line_base_nxt_s = line_base_r + {12'd0, stride_r};
                        line_cnt_nxt_s  = line_cnt_r + 16'd1;
                    end else begin
                        col_off_nxt_s = col_next_s;
                    end
                    // A completed frame wins over an abort on the same RLAST
                    if ((col_next_s == LINE_BYTES) && (line_cnt_r == LAST_LINE)) begin
                        state_nxt_s = S_IDLE;
                        done_nxt_s  = 1'b1;
                    end else if (!DISPON) begin
                        state_nxt_s = S_IDLE;
                    end else if (!FIFOREADY) begin
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_ADDR;
                    end
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_WAIT: begin
                if (!DISPON) begin
                    state_nxt_s = S_IDLE;
                end else if (FIFOREADY) begin
                    state_nxt_s = S_ADDR;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, pointers and registered AXI/status outputs
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_r     <= S_IDLE;
            line_base_r <= 28'd0;
            col_off_r   <= 28'd0;
            stride_r    <= 16'd0;
            line_cnt_r  <= 16'd0;
            araddr_r    <= 32'd0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            busy_r      <= 1'b0;
            framedone_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            line_base_r <= line_base_nxt_s;
            col_off_r   <= col_off_nxt_s;
            stride_r    <= stride_nxt_s;
            line_cnt_r  <= line_cnt_nxt_s;
            araddr_r    <= {ADDR_HI, line_base_nxt_s + col_off_nxt_s};
            arvalid_r   <= (state_nxt_s == S_ADDR);
            rready_r    <= (state_nxt_s == S_DATA);
            busy_r      <= (state_nxt_s != S_IDLE);
            framedone_r <= done_nxt_s;
        end
    end

`ifdef DISP_FETCH_RRESP_CHECK_EN
    logic rderr_r;

    assign RDERR = rderr_r;

    // Sticky error flag for SLVERR/DECERR beats, cleared on frame start
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            rderr_r <= 1'b0;
        end else if (start_s) begin
            rderr_r <= 1'b0;
        end else if (RVALID && rready_r && (RRESP inside {2'b10, 2'b11})) begin
            rderr_r <= 1'b1;
        end else begin
            rderr_r <= rderr_r;
        end
    end
`endif

endmodule

// File: tb/tb_disp_fetch_ctrl.sv
// Scoreboard bench for disp_fetch_ctrl: randomized AXI slave timing and frames,
// expected AR addresses computed from frame base/stride arithmetic.
`timescale 1ns/1ps

module tb_disp_fetch_ctrl;

    localparam int H     = 64;
    localparam int V     = 4;
    localparam int BPP   = 2;
    localparam int BUS   = 8;
    localparam int BURST = 64;
    localparam int BPL   = H * BPP / BURST;
    localparam int NB    = BPL * V;
    localparam int BEATS = BURST / BUS;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
    logic        AXISTART, DISPON, FIFOREADY, BUSY, FRAMEDONE;
    logic [27:0] DISPADDR;
    logic [15:0] DISPSTRIDE;
`ifdef DISP_FETCH_RRESP_CHECK_EN
    logic [1:0]  RRESP;
    logic        RDERR;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int exp_done = 0;
    int burst_idx = 0;
    int slow_burst = -1;
    int fifo_drop_burst = -1;
    int dispon_drop_burst = -1;
    int err_burst = -1;

    disp_fetch_ctrl #(
        .H_PIXELS(H), .V_LINES(V), .BYTES_PP(BPP), .BUS_BYTES(BUS),
        .BURST_BYTES(BURST), .ADDR_HI(4'h1)
    ) dut (
        .ACLK(ACLK), .ARST(ARST), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RVALID(RVALID),
        .RLAST(RLAST), .RREADY(RREADY),
`ifdef DISP_FETCH_RRESP_CHECK_EN
        .RRESP(RRESP), .RDERR(RDERR),
`endif
        .AXISTART(AXISTART), .DISPON(DISPON), .DISPADDR(DISPADDR),
        .DISPSTRIDE(DISPSTRIDE), .FIFOREADY(FIFOREADY), .BUSY(BUSY), .FRAMEDONE(FRAMEDONE)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Burst k of a frame: line k/BPL, column chunk k%BPL, 28-bit wrap
    function automatic logic [31:0] model_addr(input logic [27:0] base, input logic [15:0] stride,
                                               input int k);
        logic [27:0] off;
        off = base + 28'(k / BPL) * {12'd0, stride} + 28'((k % BPL) * BURST);
        return {4'h1, off};
    endfunction

    // Monitor: samples 1 ns before each rising edge
    initial begin
        logic        prev_wait;
        logic [31:0] prev_addr;
        logic [31:0] e;
        prev_wait = 1'b0;
        prev_addr = 32'd0;
        forever begin
            @(negedge ACLK);
            #4;
            if (prev_wait) begin
                check("arvalid_hold", 32'(ARVALID), 32'd1);
                check("araddr_stable", ARADDR, prev_addr);
            end
            if (ARVALID && ARREADY) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ar: got %h expected none", ARADDR);
                end else begin
                    e = exp_q.pop_front();
                    check("araddr", ARADDR, e);
                    check("arlen", 32'(ARLEN), 32'd7);
                    check("arsize", 32'(ARSIZE), 32'd3);
                    check("arburst", 32'(ARBURST), 32'd1);
                end
            end
            if (FRAMEDONE) begin
                n_cmp++;
                if (exp_done == 0) begin
                    n_err++;
                    $display("FAIL unexpected_framedone: got 1 expected 0");
                end else begin
                    exp_done--;
                end
            end
            prev_wait = ARVALID && !ARREADY;
            prev_addr = ARADDR;
        end
    end

    // AXI read slave with random handshake and beat gaps
    initial begin
        int d;
        int to;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RLAST   = 1'b0;
`ifdef DISP_FETCH_RRESP_CHECK_EN
        RRESP   = 2'b00;
`endif
        forever begin
            @(negedge ACLK);
            if (ARVALID && !ARST) begin
                d = (burst_idx == slow_burst) ? 10 : int'($urandom_range(0, 2));
                repeat (d) @(negedge ACLK);
                ARREADY = 1'b1;
                @(negedge ACLK);
                ARREADY = 1'b0;
                for (int b = 0; b < BEATS; b++) begin
                    repeat ($urandom_range(0, 1)) @(negedge ACLK);
                    RVALID = 1'b1;
                    RLAST  = (b == BEATS - 1);
`ifdef DISP_FETCH_RRESP_CHECK_EN
                    RRESP  = (burst_idx == err_burst && b == 4) ? 2'b10 : 2'b00;
`endif
                    if (b == BEATS - 1 && burst_idx == fifo_drop_burst) FIFOREADY = 1'b0;
                    if (b == 3 && burst_idx == dispon_drop_burst) DISPON = 1'b0;
                    to = 0;
                    while (!RREADY && to < 50) begin
                        @(negedge ACLK);
                        to++;
                    end
                    if (to >= 50) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rready_timeout: got 0 expected 1 (burst %0d beat %0d)", burst_idx, b);
                    end
                    @(negedge ACLK);
                    RVALID = 1'b0;
                    RLAST  = 1'b0;
`ifdef DISP_FETCH_RRESP_CHECK_EN
                    RRESP  = 2'b00;
`endif
                end
                if (burst_idx == fifo_drop_burst) begin
                    for (int w = 0; w < 6; w++) begin
                        check("arvalid_in_wait", 32'(ARVALID), 32'd0);
                        @(negedge ACLK);
                    end
                    FIFOREADY = 1'b1;
                end
                burst_idx++;
            end
        end
    end

    task automatic pulse_start();
        AXISTART = 1'b1;
        repeat (3) @(negedge ACLK);
        AXISTART = 1'b0;
    endtask

    task automatic run_frame(input logic [27:0] base, input logic [15:0] stride,
                             input int nbursts, input bit done, input bit restart);
        int to;
        burst_idx = 0;
        for (int k = 0; k < nbursts; k++) exp_q.push_back(model_addr(base, stride, k));
        if (done) exp_done++;
        DISPADDR   = base;
        DISPSTRIDE = stride;
        DISPON     = 1'b1;
        pulse_start();
        to = 0;
        while (!BUSY && to < 20) begin
            @(negedge ACLK);
            to++;
        end
        check("busy_rise", 32'(BUSY), 32'd1);
`ifdef DISP_FETCH_RRESP_CHECK_EN
        check("rderr_cleared", 32'(RDERR), 32'd0);
`endif
        if (restart) begin
            repeat (15) @(negedge ACLK);
            pulse_start();
        end
        to = 0;
        while (BUSY && to < 3000) begin
            @(negedge ACLK);
            to++;
        end
        check("busy_fall", 32'(BUSY), 32'd0);
        repeat (20) @(negedge ACLK);
        check("busy_idle", 32'(BUSY), 32'd0);
        check("ar_remaining", 32'(exp_q.size()), 32'd0);
        check("done_remaining", 32'(exp_done), 32'd0);
        exp_q.delete();
        exp_done = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARST       = 1'b1;
        AXISTART   = 1'b0;
        DISPON     = 1'b0;
        DISPADDR   = 28'd0;
        DISPSTRIDE = 16'd0;
        FIFOREADY  = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_arvalid", 32'(ARVALID), 32'd0);
        check("rst_rready", 32'(RREADY), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_framedone", 32'(FRAMEDONE), 32'd0);
        ARST = 1'b0;
        repeat (3) @(negedge ACLK);
        check("post_rst_busy", 32'(BUSY), 32'd0);

        // Basic frame, with a second start request while busy
        run_frame(28'h000_0100, 16'd128, NB, 1'b1, 1'b1);
        // Wider stride
        run_frame(28'h000_0100, 16'd256, NB, 1'b1, 1'b0);
        // Slow address handshake on burst 3
        slow_burst = 3;
        run_frame(28'h000_0100, 16'd128, NB, 1'b1, 1'b0);
        slow_burst = -1;
        // FIFO back-pressure after the third burst
        fifo_drop_burst = 2;
        run_frame(28'h000_0100, 16'd128, NB, 1'b1, 1'b0);
        fifo_drop_burst = -1;
        // Display disabled during burst 2: two bursts then abort
        dispon_drop_burst = 1;
        run_frame(28'h000_0100, 16'd128, 2, 1'b0, 1'b0);
        dispon_drop_burst = -1;
        // Address wrap at the top of the window, with an error beat
        err_burst = 1;
        run_frame(28'hFFF_FFC0, 16'd128, NB, 1'b1, 1'b0);
        err_burst = -1;
        check("wrap_model", model_addr(28'hFFF_FFC0, 16'd128, 1), 32'h1000_0000);
`ifdef DISP_FETCH_RRESP_CHECK_EN
        check("rderr_set", 32'(RDERR), 32'd1);
`endif
        // Randomized frames, including overlapping and zero strides
        for (int f = 0; f < 6; f++) begin
            logic [27:0] b;
            logic [15:0] s;
            b = 28'($urandom);
            case (f % 3)
                0: s = 16'd0;
                1: s = 16'($urandom_range(1, 127));
                default: s = 16'($urandom);
            endcase
            fifo_drop_burst = int'($urandom_range(0, NB));
            run_frame(b, s, NB, 1'b1, 1'b0);
        end
        fifo_drop_burst = -1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
